// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage, IF/ID register and hazard unit:
// default widths and the fetch sequencer state encoding.
package ifu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned ADDR_W = 20;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control/result bundle between the pipeline (master) and the fetch unit (slave).
interface instruction_fetch_unit_if #(
  parameter int unsigned DATA_W = ifu_pkg::DATA_W,
  parameter int unsigned PC_W   = ifu_pkg::PC_W,
  parameter int unsigned ADDR_W = ifu_pkg::ADDR_W
);

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              stall;
  logic              redirect_en;
  logic [PC_W-1:0]   redirect_pc;

  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] immediate;
  logic [PC_W-1:0]   pc_out;
  logic              valid;
  logic              is_long;
  logic              fetch_err;

  modport master (
    output load_en, load_addr, load_data, stall, redirect_en, redirect_pc,
    input  instruction, immediate, pc_out, valid, is_long, fetch_err
  );

  modport slave (
    input  load_en, load_addr, load_data, stall, redirect_en, redirect_pc,
    output instruction, immediate, pc_out, valid, is_long, fetch_err
  );

endinterface

// File: rtl/ifu_program_ram.sv
// Program memory: one synchronous write port, two asynchronous read ports
// at addr and addr+1 (wrapping) so an instruction and its immediate read together.
module ifu_program_ram
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_W = ifu_pkg::DATA_W,
  parameter int unsigned ADDR_W = ifu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1
);

  logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
  logic [ADDR_W-1:0] w_raddr1;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_raddr1 = i_raddr + ADDR_W'(1);
  assign o_rdata0 = r_mem[i_raddr];
  assign o_rdata1 = r_mem[w_raddr1];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline stage 1: boot-vector load, variable-length fetch, stall hold,
// redirect with one bubble, runtime program load and sticky range fault.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_W         = ifu_pkg::DATA_W,
  parameter int unsigned PC_W           = ifu_pkg::PC_W,
  parameter int unsigned ADDR_W         = ifu_pkg::ADDR_W,
  parameter int unsigned RESET_VEC_ADDR = 0,
  parameter int unsigned LONG_BIT       = 15
) (
  input logic                    clk,
  input logic                    rst_n,
  instruction_fetch_unit_if.slave bus
);

  // One bit wider than the PC so 2**ADDR_W is representable even when ADDR_W == PC_W.
  localparam logic [PC_W:0] DEPTH = (PC_W+1)'({1'b1, {ADDR_W{1'b0}}});

  ifu_state_e r_state, w_state_nxt;

  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_instruction, w_instruction_nxt;
  logic [DATA_W-1:0] r_immediate, w_immediate_nxt;
  logic [PC_W-1:0]   r_pc_out, w_pc_out_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_is_long, w_is_long_nxt;
  logic              r_fetch_err, w_fetch_err_nxt;

  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd0, w_rd1;
  logic [PC_W-1:0]   w_boot_pc;
  logic [PC_W:0]     w_pc_plus1;
  logic              w_rd_long;
  logic              w_pc_oor, w_fault, w_redir_ok;

  ifu_program_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .i_we     (bus.load_en),
    .i_waddr  (bus.load_addr),
    .i_wdata  (bus.load_data),
    .i_raddr  (w_rd_addr),
    .o_rdata0 (w_rd0),
    .o_rdata1 (w_rd1)
  );

  // The read port doubles as the boot-vector reader while in BOOT.
  assign w_rd_addr  = (r_state == BOOT) ? ADDR_W'(RESET_VEC_ADDR) : r_pc[ADDR_W-1:0];
  assign w_boot_pc  = PC_W'({w_rd1, w_rd0});
  assign w_rd_long  = w_rd0[LONG_BIT];
  assign w_pc_plus1 = {1'b0, r_pc} + (PC_W+1)'(1);
  assign w_pc_oor   = ({1'b0, r_pc} >= DEPTH);
  // Memory data only matters once pc itself is known to be in range.
  assign w_fault    = w_pc_oor || (w_rd_long && (w_pc_plus1 >= DEPTH));
  assign w_redir_ok = ({1'b0, bus.redirect_pc} < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT: if (!bus.load_en) w_state_nxt = RUN;
      RUN:  if (!bus.load_en && !bus.redirect_en && !bus.stall && w_fault) w_state_nxt = HALT;
      HALT: if (!bus.load_en && bus.redirect_en && w_redir_ok) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_comb begin
    w_pc_nxt          = r_pc;
    w_instruction_nxt = r_instruction;
    w_immediate_nxt   = r_immediate;
    w_pc_out_nxt      = r_pc_out;
    w_valid_nxt       = r_valid;
    w_is_long_nxt     = r_is_long;
    w_fetch_err_nxt   = r_fetch_err;
    unique case (r_state)
      BOOT: begin
        if (!bus.load_en) w_pc_nxt = w_boot_pc;
      end
      RUN: begin
        if (bus.load_en) begin
          w_valid_nxt = 1'b0;
        end else if (bus.redirect_en) begin
          w_pc_nxt          = bus.redirect_pc;
          w_valid_nxt       = 1'b0;
          w_instruction_nxt = '0;
          w_immediate_nxt   = '0;
          w_is_long_nxt     = 1'b0;
        end else if (bus.stall) begin
          w_valid_nxt = r_valid;
        end else if (w_fault) begin
          w_fetch_err_nxt = 1'b1;
          w_valid_nxt     = 1'b0;
        end else begin
          w_instruction_nxt = w_rd0;
          w_is_long_nxt     = w_rd_long;
          w_immediate_nxt   = w_rd_long ? w_rd1 : '0;
          w_pc_out_nxt      = r_pc;
          w_valid_nxt       = 1'b1;
          w_pc_nxt          = r_pc + PC_W'(w_rd_long ? 2 : 1);
        end
      end
      HALT: begin
        if (!bus.load_en && bus.redirect_en && w_redir_ok) begin
          w_pc_nxt          = bus.redirect_pc;
          w_fetch_err_nxt   = 1'b0;
          w_instruction_nxt = '0;
          w_immediate_nxt   = '0;
          w_is_long_nxt     = 1'b0;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_instruction <= '0;
      r_immediate   <= '0;
      r_pc_out      <= '0;
      r_valid       <= 1'b0;
      r_is_long     <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_instruction <= w_instruction_nxt;
      r_immediate   <= w_immediate_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_valid       <= w_valid_nxt;
      r_is_long     <= w_is_long_nxt;
      r_fetch_err   <= w_fetch_err_nxt;
    end
  end

  assign bus.instruction = r_instruction;
  assign bus.immediate   = r_immediate;
  assign bus.pc_out      = r_pc_out;
  assign bus.valid       = r_valid;
  assign bus.is_long     = r_is_long;
  assign bus.fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus queues expected
// fetches; a monitor compares each fresh valid output against the queue head.
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        lng;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.DATA_W(16), .PC_W(32), .ADDR_W(20)) bus ();

  instruction_fetch_unit #(
    .DATA_W         (16),
    .PC_W           (32),
    .ADDR_W         (20),
    .RESET_VEC_ADDR (0),
    .LONG_BIT       (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},   32'(bus.valid),       32'h0);
    check({tag, "_instr"},   32'(bus.instruction), 32'h0);
    check({tag, "_imm"},     32'(bus.immediate),   32'h0);
    check({tag, "_pc_out"},  bus.pc_out,           32'h0);
    check({tag, "_is_long"}, 32'(bus.is_long),     32'h0);
    check({tag, "_err"},     32'(bus.fetch_err),   32'h0);
  endtask

  task automatic drive_idle();
    bus.load_en     = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect_en = 1'b0;
  endtask

  task automatic load_word(input logic [19:0] a, input logic [15:0] d);
    @(negedge clk);
    drive_idle();
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [15:0] ins, input logic [15:0] imm, input logic lng);
    @(negedge clk);
    drive_idle();
    q.push_back({pc, ins, imm, lng});
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic stall_cycle();
    @(negedge clk);
    drive_idle();
    bus.stall = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic with_stall);
    @(negedge clk);
    drive_idle();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = tgt;
    bus.stall       = with_stall;
    @(posedge clk);
    #1;
  endtask

  // A valid output after an edge with stall low is a fresh fetch.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.valid && !bus.stall) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fetch: got pc_out=0x%0h, expected no fetch", bus.pc_out);
        end else begin
          m_e = q.pop_front();
          check("fetch_pc_out",  bus.pc_out,           m_e.pc);
          check("fetch_instr",   32'(bus.instruction), 32'(m_e.instr));
          check("fetch_imm",     32'(bus.immediate),   32'(m_e.imm));
          check("fetch_is_long", 32'(bus.is_long),     32'(m_e.lng));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [19:0] prog_a [13] = '{20'h00000, 20'h00001, 20'h00010, 20'h00011, 20'h00012,
                               20'h00013, 20'h00040, 20'h00041, 20'h00042, 20'h00005,
                               20'h00006, 20'hFFFFE, 20'hFFFFF};
  logic [15:0] prog_d [13] = '{16'h0010, 16'h0000, 16'h8001, 16'hABCD, 16'h0002,
                               16'h0013, 16'h0040, 16'h0000, 16'h0042, 16'h0005,
                               16'h0006, 16'h0EEE, 16'h8000};

  initial begin
    drive_idle();
    bus.load_addr   = '0;
    bus.load_data   = '0;
    bus.redirect_pc = '0;
    #1 rst_n = 1'b0;
    #2;
    check_zero_outputs("reset");

    for (int i = 0; i < 13; i++) load_word(prog_a[i], prog_d[i]);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("boot_valid", 32'(bus.valid), 32'h0);

    fetch(32'h10, 16'h8001, 16'hABCD, 1'b1);
    fetch(32'h12, 16'h0002, 16'h0000, 1'b0);
    fetch(32'h13, 16'h0013, 16'h0000, 1'b0);

    for (int i = 0; i < 3; i++) begin
      stall_cycle();
      check("stall_pc_out", bus.pc_out,           32'h13);
      check("stall_instr",  32'(bus.instruction), 32'h13);
      check("stall_valid",  32'(bus.valid),       32'h1);
    end

    redirect(32'h40, 1'b1);
    check("bubble_valid",   32'(bus.valid),       32'h0);
    check("bubble_instr",   32'(bus.instruction), 32'h0);
    check("bubble_imm",     32'(bus.immediate),   32'h0);
    check("bubble_is_long", 32'(bus.is_long),     32'h0);
    fetch(32'h40, 16'h0040, 16'h0000, 1'b0);

    load_word(20'h00041, 16'h1234);
    @(posedge clk);
    #1;
    check("load_run_valid", 32'(bus.valid), 32'h0);
    fetch(32'h41, 16'h1234, 16'h0000, 1'b0);
    fetch(32'h42, 16'h0042, 16'h0000, 1'b0);

    redirect(32'h0010_0000, 1'b0);
    check("oor_bubble_err", 32'(bus.fetch_err), 32'h0);
    idle_cycle();
    check("oor_fault_err",   32'(bus.fetch_err), 32'h1);
    check("oor_fault_valid", 32'(bus.valid),     32'h0);
    idle_cycle();
    check("halt_err_sticky", 32'(bus.fetch_err), 32'h1);
    check("halt_valid",      32'(bus.valid),     32'h0);

    redirect(32'h5, 1'b0);
    check("recover_err",   32'(bus.fetch_err), 32'h0);
    check("recover_valid", 32'(bus.valid),     32'h0);
    fetch(32'h5, 16'h0005, 16'h0000, 1'b0);
    fetch(32'h6, 16'h0006, 16'h0000, 1'b0);

    redirect(32'h000F_FFFE, 1'b0);
    fetch(32'h000F_FFFE, 16'h0EEE, 16'h0000, 1'b0);
    idle_cycle();
    check("long_top_err",   32'(bus.fetch_err), 32'h1);
    check("long_top_valid", 32'(bus.valid),     32'h0);

    redirect(32'h0020_0000, 1'b0);
    check("halt_bad_redirect_err", 32'(bus.fetch_err), 32'h1);
    redirect(32'h10, 1'b0);
    check("halt_good_redirect_err", 32'(bus.fetch_err), 32'h0);
    fetch(32'h10, 16'h8001, 16'hABCD, 1'b1);

    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");

    load_word(20'h00000, 16'h0040);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reboot_valid", 32'(bus.valid), 32'h0);
    fetch(32'h40, 16'h0040, 16'h0000, 1'b0);
    fetch(32'h41, 16'h1234, 16'h0000, 1'b0);
    fetch(32'h42, 16'h0042, 16'h0000, 1'b0);

    stall_cycle();
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Parametrised successor to the single-word instruction memory: owns the program memory, the PC register and the fetch sequencing for stage 1 of the five-stage pipeline.
- Supports variable-length instructions: a short instruction is one word; a long instruction is one word plus an immediate word.
- Adds a boot-vector load, stall hold, branch/jump redirect with bubble insertion, a runtime program-load write port and out-of-range fault detection.
- Output feeds the IF/ID pipeline register directly.

Parameters:
- DATA_W, 16, instruction/immediate word width.
- PC_W, 32, program counter width.
- ADDR_W, 20, memory address width; depth = 2**ADDR_W words.
- RESET_VEC_ADDR, 0, word address of the low half of the boot vector.
- LONG_BIT, 15, instruction bit that marks a long instruction when set; must be < DATA_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  write word address.
- load_data  in  DATA_W  write data.
- stall  in  1  hazard unit hold request.
- redirect_en  in  1  branch/jump taken, from EX.
- redirect_pc  in  PC_W  redirect target.
- instruction  out  DATA_W  fetched instruction word.
- immediate  out  DATA_W  immediate word; 0 for short instructions.
- pc_out  out  PC_W  address of the fetched instruction.
- valid  out  1  instruction/immediate/pc_out are meaningful.
- is_long  out  1  fetched instruction is long.
- fetch_err  out  1  sticky out-of-range fault.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=0, state=BOOT.
  - instruction, immediate, pc_out, valid, is_long and fetch_err all 0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts the fetch in flight. No partial output may appear.
- Memory writes:
  - Synchronous write mem[load_addr]<=load_data when load_en=1, in any state.
  - A read in the same cycle at the same address returns the old data.
- States: BOOT, RUN, HALT. Priority within a cycle: load_en > redirect_en > stall > normal fetch.
- BOOT:
  - With load_en=0, the block takes one cycle: pc <= low PC_W bits of {mem[RESET_VEC_ADDR+1], mem[RESET_VEC_ADDR]}, then goes to RUN.
  - valid stays 0.
  - If load_en=1, BOOT holds.
- RUN, normal fetch (load_en=0, redirect_en=0, stall=0), latency 1 cycle, registered:
  - instruction<=mem[pc]; is_long<=mem[pc][LONG_BIT].
  - immediate<=is_long ? mem[pc+1] : 0.
  - pc_out<=pc; valid<=1.
  - pc<=pc+(long?2:1), modulo 2**PC_W.
- Stall: pc and all outputs hold their values; valid is unchanged.
- Redirect:
  - pc<=redirect_pc.
  - Next cycle valid=0, instruction=0, immediate=0, is_long=0 (one bubble).
  - Fetch from the target starts the following cycle.
  - Redirect overrides stall.
- load_en=1 in RUN: fetch is suppressed, pc holds, valid<=0.
- Range check, applied in RUN before the fetch:
  - Fault when pc >= 2**ADDR_W, or when the instruction is long and pc+1 >= 2**ADDR_W.
  - On fault: fetch_err<=1, valid<=0, go to HALT.
- HALT:
  - Outputs hold with valid=0.
  - redirect_en to an in-range target clears fetch_err and returns to RUN at the target.
  - A redirect to an out-of-range target stays in HALT.
  - Reset also exits HALT.
- Memory index uses pc[ADDR_W-1:0] only after the range check has passed.

Decomposition:
- Shared package ifu_pkg holds the state enum (BOOT, RUN, HALT) and the default width constants DATA_W, PC_W and ADDR_W, shared with the IF/ID register and the hazard unit.
- One sub-module, ifu_program_ram: 1 write port, 2 asynchronous read ports (addr, addr+1), parametrised by DATA_W and ADDR_W.
- FSM, PC logic and output registers stay in the top module.

Test Plan:
- Boot vector: mem[0]=0x0010, mem[1]=0x0000; release rst_n -> BOOT for 1 cycle, then first valid fetch with pc_out=0x10.
- Mixed lengths: mem[0x10]=0x8001 (long), mem[0x11]=0xABCD, mem[0x12]=0x0002 (short).
  - Expect fetch 1: pc_out=0x10, immediate=0xABCD, is_long=1.
  - Expect fetch 2: pc_out=0x12, immediate=0, is_long=0.
- Stall and redirect: assert stall for 3 cycles -> outputs frozen. Assert redirect_en with redirect_pc=0x40 together with stall -> one bubble (valid=0), then pc_out=0x40.
- Load during run: load_en writes 0x1234 to 0x41 while pc=0x41 -> valid=0 that cycle; after load_en drops, instruction=0x1234.
- Fault:
  - Redirect to 2**ADDR_W -> fetch_err=1, HALT, valid=0.
  - Redirect to 0x5 -> fetch_err=0, fetch resumes at 0x5.
  - Separately, a long instruction at 2**ADDR_W-1 -> fetch_err=1.
- Async reset mid-fetch: drop rst_n between clock edges -> all outputs 0 immediately; mem contents intact; re-boot re-reads the vector.
